sim_scheduler: RTL and testbench

- Sequences the game-of-life datapath. It decides when the logic engine runs a generation, and it shares the board memory port between generation steps and user cell toggles.
- It consumes the debounced click, cursor position and speed setting from the user-interface block.
- It issues one-cycle step-start pulses to the logic engine.
- It performs read-modify-write toggles of the board cell under the cursor, but only while the engine is idle.

---
 rtl/sim_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_sim_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_scheduler.sv
// Game-of-life sequencer: paces generation steps from the frame timer or the
// single-step button, and shares the board port between the engine and
// read-modify-write cell toggles at the cursor.
module sim_scheduler #(
  parameter int LOG_BOARD_SIZE = 9,
  parameter int LOG_MAX_SPEED  = 4,
  parameter int RD_LATENCY     = 2,
  parameter int LOG_TIMEOUT    = 24
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        frame_tick_in,
  input  logic [LOG_MAX_SPEED-1:0]    speed_in,
  input  logic                        click_in,
  input  logic                        step_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0]   cursor_y_in,
  input  logic                        logic_done_in,
  output logic                        step_start_out,
  output logic                        mem_re_out,
  output logic                        mem_we_out,
  output logic [2*LOG_BOARD_SIZE-1:0] mem_addr_out,
  output logic                        mem_wdata_out,
  input  logic                        mem_rdata_in,
  output logic                        busy_out,
  output logic [15:0]                 gen_count_out,
  output logic                        timeout_out
);

  localparam int AW = 2*LOG_BOARD_SIZE;
  localparam int LW = $clog2(RD_LATENCY+1);
  localparam int SW = LOG_MAX_SPEED+1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EDIT_RD   = 3'd1;
  localparam logic [2:0] S_EDIT_WAIT = 3'd2;
  localparam logic [2:0] S_EDIT_WR   = 3'd3;
  localparam logic [2:0] S_START     = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;

  // Frames per step at speed s is 2**LOG_MAX_SPEED - s.
  localparam logic [SW-1:0]          SPD_FULL = SW'(2**LOG_MAX_SPEED);
  // Last watchdog value before the run is abandoned; the run then lasts
  // 2**LOG_TIMEOUT-1 cycles in total.
  localparam logic [LOG_TIMEOUT-1:0] WD_LAST  = LOG_TIMEOUT'(2**LOG_TIMEOUT - 2);

  logic [2:0]               state_q, state_d;
  logic                     click_q, step_q;
  logic                     pend_q, pend_d;
  logic [AW-1:0]            pend_addr_q, pend_addr_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [LW-1:0]            lat_q, lat_d;
  logic                     rdata_q, rdata_d;
  logic [LOG_MAX_SPEED-1:0] frame_cnt_q, frame_cnt_d;
  logic                     due_q, due_d;
  logic [LOG_TIMEOUT-1:0]   wd_q, wd_d;
  logic [15:0]              gen_q, gen_d;
  logic                     tmo_q, tmo_d;

  logic          click_rise, step_fire, tmr_fire;
  logic          enter_edit, enter_start;
  logic [SW-1:0] fc_inc, thr;

  assign click_rise  = click_in & ~click_q;
  assign enter_edit  = (state_q == S_IDLE) & pend_q;
  assign enter_start = (state_q == S_IDLE) & ~pend_q & due_q;
  assign fc_inc      = {1'b0, frame_cnt_q} + SW'(1);
  assign thr         = SPD_FULL - {1'b0, speed_in};

  // Click capture, one deep; the pending slot frees when the edit begins,
  // and the active edit keeps its own address so new clicks can queue.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (enter_edit) begin
      pend_d = 1'b0;
    end else if (click_rise && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = {cursor_y_in, cursor_x_in};
    end
  end

  // Frame timer and single-step trigger; a trigger landing on the START
  // entry cycle merges into the step being launched.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    tmr_fire    = 1'b0;
    if (speed_in == '0) begin
      frame_cnt_d = '0;
    end else if (frame_tick_in) begin
      if (fc_inc >= thr) begin
        tmr_fire    = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = fc_inc[LOG_MAX_SPEED-1:0];
      end
    end
    step_fire = step_in & ~step_q & (speed_in == '0);
    due_d     = enter_start ? 1'b0 : (due_q | tmr_fire | step_fire);
  end

  // Main sequencer: edits win over steps, runs end on done or watchdog.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    wd_d    = wd_q;
    gen_d   = gen_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_EDIT_RD;
          addr_d  = pend_addr_q;
        end else if (due_q) begin
          state_d = S_START;
        end
      end
      S_EDIT_RD: begin
        state_d = S_EDIT_WAIT;
        lat_d   = LW'(1);
      end
      S_EDIT_WAIT: begin
        if (lat_q == LW'(RD_LATENCY)) begin
          rdata_d = mem_rdata_in;
          state_d = S_EDIT_WR;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_EDIT_WR: state_d = S_IDLE;
      S_START: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        if (logic_done_in) begin
          state_d = S_IDLE;
          gen_d   = gen_q + 16'd1;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          wd_d = wd_q + LOG_TIMEOUT'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      click_q     <= 1'b0;
      step_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      addr_q      <= '0;
      lat_q       <= '0;
      rdata_q     <= 1'b0;
      frame_cnt_q <= '0;
      due_q       <= 1'b0;
      wd_q        <= '0;
      gen_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      click_q     <= click_in;
      step_q      <= step_in;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      rdata_q     <= rdata_d;
      frame_cnt_q <= frame_cnt_d;
      due_q       <= due_d;
      wd_q        <= wd_d;
      gen_q       <= gen_d;
      tmo_q       <= tmo_d;
    end
  end

  logic in_edit;
  assign in_edit = (state_q == S_EDIT_RD) | (state_q == S_EDIT_WAIT) | (state_q == S_EDIT_WR);

  // Outputs decode straight from the state, so reset clears them at once.
  assign step_start_out = (state_q == S_START);
  assign mem_re_out     = (state_q == S_EDIT_RD);
  assign mem_we_out     = (state_q == S_EDIT_WR);
  assign mem_addr_out   = in_edit ? addr_q : '0;
  assign mem_wdata_out  = (state_q == S_EDIT_WR) & ~rdata_q;
  assign busy_out       = (state_q != S_IDLE);
  assign gen_count_out  = gen_q;
  assign timeout_out    = tmo_q;

endmodule

// File: tb/tb_sim_scheduler.sv
// Bench for sim_scheduler: directed scenarios plus randomized traffic, all
// compared each cycle against an activity-level reference model.
module tb_sim_scheduler;
  localparam int LBS = 4, LMS = 4, RDL = 2, LTO = 4;
  localparam int AW = 2*LBS;
  localparam int NCELL = 1 << AW;
  localparam int RUN_BUDGET = (1 << LTO) - 1;
  localparam int A_IDLE = 0, A_EDIT = 1, A_START = 2, A_RUN = 3;

  logic clk = 0, rst_n = 0, frame_tick = 0, click = 0, step = 0, done = 0, rdata = 0;
  logic [LMS-1:0] speed = 0;
  logic [LBS-1:0] cur_x = 0, cur_y = 0;
  logic start_o, re_o, we_o, wd_o, busy_o, tmo_o;
  logic [AW-1:0] addr_o;
  logic [15:0] gen_o;

  sim_scheduler #(.LOG_BOARD_SIZE(LBS), .LOG_MAX_SPEED(LMS), .RD_LATENCY(RDL),
                  .LOG_TIMEOUT(LTO)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .frame_tick_in(frame_tick), .speed_in(speed),
    .click_in(click), .step_in(step), .cursor_x_in(cur_x), .cursor_y_in(cur_y),
    .logic_done_in(done), .step_start_out(start_o), .mem_re_out(re_o),
    .mem_we_out(we_o), .mem_addr_out(addr_o), .mem_wdata_out(wd_o),
    .mem_rdata_in(rdata), .busy_out(busy_o), .gen_count_out(gen_o),
    .timeout_out(tmo_o));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_re = 0, n_we = 0, n_start = 0;
  int last_re_cyc = 0, last_we_cyc = 0, last_start_cyc = 0, last_re_addr = 0, last_we_wd = 0;
  // stimulus knobs
  int p_click = 0, p_step = 0, p_tick = 0, p_spur = 0, lat_min = 5, lat_max = 5;
  // environment: board memory and engine
  bit env_mem [NCELL];
  bit pipe_v [RDL];
  int pipe_a [RDL];
  int eng_cnt = 0;
  bit s_re, s_we, s_wd, s_start;
  int s_addr;
  // reference model
  bit ref_mem [NCELL];
  int m_act, m_el, m_paddr, m_eaddr, m_fc, m_gen;
  bit m_pend, m_samp, m_due, m_tmo, m_pclick, m_pstep;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic m_reset();
    m_act = A_IDLE; m_el = 0; m_paddr = 0; m_eaddr = 0; m_fc = 0; m_gen = 0;
    m_pend = 0; m_samp = 0; m_due = 0; m_tmo = 0; m_pclick = 0; m_pstep = 0;
    for (int i = 0; i < RDL; i++) begin pipe_v[i] = 0; pipe_a[i] = 0; end
    eng_cnt = 0; s_re = 0; s_we = 0; s_wd = 0; s_start = 0; s_addr = 0;
  endtask

  // One clock of the specified behaviour, using the inputs held this cycle.
  task automatic m_step();
    bit rise_c, trig, old_pend, launched;
    int n;
    rise_c = click && !m_pclick;
    trig = step && !m_pstep && (speed == 0);
    m_pclick = click; m_pstep = step;
    if (speed == 0) m_fc = 0;
    else if (frame_tick) begin
      n = m_fc + 1;
      if (n >= (1 << LMS) - int'(speed)) begin trig = 1; m_fc = 0; end
      else m_fc = n;
    end
    old_pend = m_pend; launched = 0;
    case (m_act)
      A_IDLE:
        if (m_pend) begin m_act = A_EDIT; m_el = 0; m_eaddr = m_paddr; m_pend = 0; end
        else if (m_due) begin m_act = A_START; m_due = 0; launched = 1; end
      A_EDIT: begin
        if (m_el == RDL) m_samp = ref_mem[m_eaddr];
        if (m_el == RDL + 1) begin ref_mem[m_eaddr] = !m_samp; m_act = A_IDLE; end
        else m_el++;
      end
      A_START: begin m_act = A_RUN; m_el = 0; end
      default: begin
        m_el++;
        if (done) begin m_act = A_IDLE; m_gen = (m_gen + 1) & 16'hFFFF; end
        else if (m_el == RUN_BUDGET) begin m_act = A_IDLE; m_tmo = 1; end
      end
    endcase
    if (rise_c && !old_pend) begin m_pend = 1; m_paddr = int'({cur_y, cur_x}); end
    if (trig && !launched) m_due = 1;
  endtask

  task automatic cycle();
    bit e_re, e_we;
    @(posedge clk);
    cyc++;
    if (s_we) env_mem[s_addr] = s_wd;
    for (int i = RDL - 1; i > 0; i--) begin pipe_v[i] = pipe_v[i-1]; pipe_a[i] = pipe_a[i-1]; end
    pipe_v[0] = s_re; pipe_a[0] = s_addr;
    if (s_start) eng_cnt = $urandom_range(lat_max, lat_min);
    m_step();
    #1;
    frame_tick = ($urandom_range(99) < p_tick);
    if ($urandom_range(99) < p_click) begin
      click = ~click; cur_x = LBS'($urandom); cur_y = LBS'($urandom);
    end
    if ($urandom_range(99) < p_step) step = ~step;
    if (eng_cnt > 0) begin eng_cnt--; done = (eng_cnt == 0); end
    else done = ($urandom_range(999) < p_spur);
    rdata = pipe_v[RDL-1] ? env_mem[pipe_a[RDL-1]] : 1'($urandom);
    @(negedge clk);
    s_re = re_o; s_we = we_o; s_wd = wd_o; s_start = start_o; s_addr = int'(addr_o);
    e_re = (m_act == A_EDIT) && (m_el == 0);
    e_we = (m_act == A_EDIT) && (m_el == RDL + 1);
    chk("re", 32'(re_o), 32'(e_re));
    chk("we", 32'(we_o), 32'(e_we));
    chk("addr", 32'(addr_o), (m_act == A_EDIT) ? m_eaddr : 0);
    chk("wdata", 32'(wd_o), e_we ? 32'(!m_samp) : 0);
    chk("start", 32'(start_o), 32'(m_act == A_START));
    chk("busy", 32'(busy_o), 32'(m_act != A_IDLE));
    chk("gen", 32'(gen_o), m_gen);
    chk("timeout", 32'(tmo_o), 32'(m_tmo));
    if (re_o) begin n_re++; last_re_cyc = cyc; last_re_addr = int'(addr_o); end
    if (we_o) begin n_we++; last_we_cyc = cyc; last_we_wd = int'(wd_o); end
    if (start_o) begin n_start++; last_start_cyc = cyc; end
  endtask

  task automatic wait_start(input string tag, input int st0, input int limit);
    int k = 0;
    while (n_start == st0 && k < limit) begin cycle(); k++; end
    chk(tag, n_start - st0, 1);
  endtask

  task automatic step_edge();
    step = 1; cycle(); step = 0;
  endtask

  initial begin
    int r0, w0, st0, k, bad;
    for (int i = 0; i < NCELL; i++) begin env_mem[i] = 1'($urandom); ref_mem[i] = env_mem[i]; end
    m_reset();
    #3;
    chk("rst_outs", {re_o, we_o, wd_o, start_o, busy_o, tmo_o}, 0);
    chk("rst_addr_gen", {addr_o, gen_o}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1; m_reset();

    // Step timer: speed 14 fires on every second tick.
    speed = 14; lat_min = 10; lat_max = 10; st0 = n_start;
    for (int t = 0; t < 6; t++) begin
      cycle(); frame_tick = 1; cycle();
      repeat (19) cycle();
    end
    chk("timer_starts", n_start - st0, 3);
    chk("timer_gen", 32'(gen_o), 3);

    // Toggle a live cell at (5,7).
    speed = 0; env_mem[8'h75] = 1; ref_mem[8'h75] = 1;
    cycle(); r0 = n_re; w0 = n_we;
    cur_x = 5; cur_y = 7; click = 1; cycle(); click = 0;
    repeat (8) cycle();
    chk("tog_reads", n_re - r0, 1);
    chk("tog_writes", n_we - w0, 1);
    chk("tog_addr", last_re_addr, 32'h75);
    chk("tog_gap", last_we_cyc - last_re_cyc, RDL + 1);
    chk("tog_wdata", last_we_wd, 0);
    chk("tog_cell", 32'(env_mem[8'h75]), 0);

    // Edit defers a coincident step; second click queued, third dropped.
    r0 = n_re; w0 = n_we; st0 = n_start;
    cur_x = 4; cur_y = 1; click = 1; step = 1; cycle(); click = 0; step = 0;
    wait_start("defer_start", st0, 50);
    chk("defer_order", 32'(n_we - w0 == 1 && last_re_cyc < last_we_cyc), 1);
    chk("defer_gap", last_start_cyc - last_we_cyc, 2);
    cycle(); cur_x = 2; cur_y = 3; click = 1; cycle(); click = 0; cycle();
    cur_x = 9; cur_y = 9; click = 1; cycle(); click = 0;
    repeat (40) cycle();
    chk("defer_reads", n_re - r0, 2);
    chk("defer_addr2", last_re_addr, 32'h32);
    chk("defer_gen", 32'(gen_o), 4);

    // Paused: ticks do nothing, one step edge gives one generation.
    lat_min = 5; lat_max = 5; st0 = n_start; p_tick = 100;
    repeat (100) cycle();
    p_tick = 0;
    chk("pause_starts", n_start - st0, 0);
    step_edge(); repeat (30) cycle();
    chk("single_step", n_start - st0, 1);
    chk("single_gen", 32'(gen_o), 5);
    speed = 5; st0 = n_start;
    repeat (3) begin step_edge(); repeat (5) cycle(); end
    repeat (15) cycle();
    chk("step_ignored", n_start - st0, 0);

    // Watchdog: engine never answers.
    speed = 0; lat_min = 500; lat_max = 500; st0 = n_start;
    step_edge();
    wait_start("wd_start", st0, 20);
    k = 0;
    do begin cycle(); k++; end while (busy_o && k < 40);
    chk("wd_cycles", k, RUN_BUDGET + 1);
    chk("wd_flag", 32'(tmo_o), 1);
    chk("wd_gen", 32'(gen_o), 5);
    lat_min = 5; lat_max = 5; st0 = n_start;
    step_edge();
    wait_start("wd_restart", st0, 20);
    repeat (10) cycle();
    chk("wd_gen_after", 32'(gen_o), 6);

    // Asynchronous reset during the read wait.
    click = 1; cycle(); click = 0;
    k = 0;
    while (!(m_act == A_EDIT && m_el == 1) && k < 10) begin cycle(); k++; end
    chk("rst_reach_wait", 32'(m_act == A_EDIT && m_el == 1), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_outs", {re_o, we_o, wd_o, start_o, busy_o, tmo_o}, 0);
    chk("arst_addr_gen", {addr_o, gen_o}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); click = 0; step = 0; done = 0; rst_n = 1; m_reset();
    r0 = n_re; w0 = n_we;
    repeat (20) cycle();
    chk("arst_no_write", n_we - w0, 0);
    chk("arst_no_pend", n_re - r0, 0);

    // Randomized traffic.
    p_click = 15; p_step = 5; p_tick = 30; p_spur = 20; lat_min = 1; lat_max = 20;
    for (int b = 0; b < 6; b++) begin
      speed = LMS'($urandom_range(15));
      if (b == 2) speed = 0;
      repeat (400) cycle();
    end
    p_click = 0; p_step = 0; p_tick = 0; p_spur = 0;
    repeat (40) cycle();
    bad = 0;
    for (int i = 0; i < NCELL; i++) if (env_mem[i] != ref_mem[i]) bad++;
    chk("board_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
